// File: rtl/adam_periph_uart_pkg.sv
// Shared types and constants for the ADAM UART receive path.
package adam_periph_uart_pkg;

  localparam int MIN_BAUD     = 4;
  localparam int MIN_DATA_LEN = 5;
  localparam int MAX_DATA_LEN = 9;

  // Receiver frame states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    PAUSED
  } rx_state_t;

  // One received frame as stored in the receive FIFO.
  typedef struct packed {
    logic                    brk;
    logic                    frame;
    logic                    parity;
    logic [MAX_DATA_LEN-1:0] data;
  } rx_entry_t;

  // True when the requested number of data bits is one the receiver supports.
  function automatic logic data_len_ok(input logic [3:0] len);
    return (len >= 4'(MIN_DATA_LEN)) && (len <= 4'(MAX_DATA_LEN));
  endfunction

endpackage

// File: rtl/adam_periph_uart_rx_fifo.sv
// Receive FIFO: power-of-two circular buffer with occupancy count.
// A push while full is only accepted when a pop happens in the same cycle,
// because the popped slot is the one the write pointer lands on.
module adam_periph_uart_rx_fifo #(
  parameter type entry_t = logic [11:0],
  parameter int  DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   level_q;
  logic          wr_en;
  logic          rd_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem_q[rd_q];
  assign level = level_q;

  // Storage array; contents are only visible while the FIFO holds entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adam_periph_uart_rx_buf.sv
// UART receiver with majority-vote sampling, false-start filtering,
// 5..9 bit frames, per-frame error flags, receive FIFO, sticky overrun
// and a pause handshake that lets the frame in flight finish first.
//
// Pop handshake: data/data_valid/err_* describe the FIFO head; the word is
// consumed on every clock edge where data_valid && data_ready, and
// data_valid never depends on data_ready.
module adam_periph_uart_rx_buf
  import adam_periph_uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pause_req,
  output logic                        pause_ack,
  input  logic                        parity_select,
  input  logic                        parity_control,
  input  logic [3:0]                  data_length,
  input  logic [1:0]                  stop_bits,
  input  logic [DATA_WIDTH-1:0]       baud_rate,
  output logic [DATA_WIDTH-1:0]       data,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        err_parity,
  output logic                        err_frame,
  output logic                        err_break,
  output logic                        overrun,
  input  logic                        overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        rx
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  // Input conditioning.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [2:0]             hist_q;
  logic                   maj;
  logic                   start_edge;

  // Frame state.
  rx_state_t              state_q;
  rx_state_t              state_d;
  logic [DATA_WIDTH-1:0]  cnt_q;
  logic [3:0]             bit_q;
  logic [1:0]             stop_cnt_q;
  logic [MAX_DATA_LEN-1:0] shreg_q;
  logic                   par_err_q;
  logic                   frm_err_q;
  logic                   zero_q;
  logic                   tick;
  logic                   cfg_ok;
  logic                   brk_now;
  logic                   frame_now;
  logic                   push;
  logic                   pause_ack_q;

  // Configuration captured when a frame starts.
  logic [DATA_WIDTH-1:0]  baud_q;
  logic [3:0]             len_q;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic [1:0]             stopb_q;

  // FIFO side.
  rx_entry_t              push_entry;
  rx_entry_t              head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   overrun_set;
  logic                   overrun_q;

  // Bring rx into the clock domain; idle line level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Three-sample history for the majority vote and edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 3'b111;
    else        hist_q <= {hist_q[1:0], rxs};
  end

  assign maj        = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  // Requires the previous sample to be 1, so a line stuck low never retriggers.
  assign start_edge = hist_q[0] & ~rxs;
  assign cfg_ok     = (baud_rate >= DATA_WIDTH'(MIN_BAUD)) && data_len_ok(data_length);

  // First sample lands mid start bit, later ones one full bit apart.
  assign tick = (state_q == START) ? (cnt_q == (baud_q >> 1)) : (cnt_q == baud_q - ONE);

  // Break needs the first stop bit low too; on a one-stop frame that is the current sample.
  assign brk_now   = (stop_cnt_q == 2'd0) ? (zero_q & ~maj) : zero_q;
  assign frame_now = frm_err_q | ~maj | brk_now;

  assign push_entry.brk    = brk_now;
  assign push_entry.frame  = frame_now;
  assign push_entry.parity = par_err_q;
  assign push_entry.data   = shreg_q;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and push decision.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pause_req)                state_d = PAUSED;
        else if (start_edge && cfg_ok) state_d = START;
      end
      START: begin
        if (tick) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (tick && (bit_q == len_q - 4'd1)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick && (stop_cnt_q == stopb_q)) begin
          push = 1'b1;
          if (brk_now)        state_d = BREAK;
          else if (pause_req) state_d = PAUSED;
          else                state_d = IDLE;
        end
      end
      BREAK: begin
        if (rxs) state_d = pause_req ? PAUSED : IDLE;
      end
      PAUSED: begin
        if (!pause_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing, configuration capture and per-frame accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_cnt_q <= '0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      zero_q     <= 1'b0;
      baud_q     <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stopb_q    <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (state_d == START) begin
          baud_q     <= baud_rate;
          len_q      <= data_length;
          par_en_q   <= parity_control;
          par_odd_q  <= parity_select;
          stopb_q    <= stop_bits;
          cnt_q      <= '0;
          bit_q      <= '0;
          stop_cnt_q <= '0;
          shreg_q    <= '0;
          par_err_q  <= 1'b0;
          frm_err_q  <= 1'b0;
          zero_q     <= 1'b1;
        end
      end else if (state_q inside {START, DATA, PARITY, STOP}) begin
        cnt_q <= tick ? '0 : cnt_q + ONE;
      end
      if (tick) begin
        case (state_q)
          DATA: begin
            shreg_q[bit_q] <= maj;
            zero_q         <= zero_q & ~maj;
            bit_q          <= bit_q + 4'd1;
          end
          PARITY: begin
            par_err_q <= (maj != ((^shreg_q) ^ par_odd_q));
            zero_q    <= zero_q & ~maj;
          end
          STOP: begin
            if (!maj) frm_err_q <= 1'b1;
            if (stop_cnt_q == 2'd0) zero_q <= zero_q & ~maj;
            stop_cnt_q <= stop_cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Acknowledge one cycle after settling in PAUSED; drop one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause_ack_q <= 1'b0;
    else        pause_ack_q <= (state_q == PAUSED) && pause_req;
  end

  assign pause_ack = pause_ack_q;

  adam_periph_uart_rx_fifo #(
    .entry_t (rx_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign data_valid  = ~fifo_empty;
  assign pop         = data_valid & data_ready;
  assign overrun_set = push & fifo_full & ~pop;

  // Head word is forced to zero when empty so stale storage never shows.
  assign data       = data_valid ? DATA_WIDTH'(head.data) : '0;
  assign err_parity = data_valid & head.parity;
  assign err_frame  = data_valid & head.frame;
  assign err_break  = data_valid & head.brk;

  // Sticky overrun; a new overrun beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overrun_q <= 1'b0;
    else if (overrun_set) overrun_q <= 1'b1;
    else if (overrun_clr) overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;

endmodule
